// File: rtl/cartridge_load_controller.sv
// Cartridge loader: packs detected 2-bit colors into instruction words, writes
// them to program RAM, and keeps the CPU halted until the load completes.
module cartridge_load_controller #(
    parameter int WORD_NIBS = 6,
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     loadStart,
    input  logic                     loadEnd,
    input  logic                     colorValid,
    input  logic [1:0]               color,
    input  logic [ADDR_W-1:0]        cpuAddress,
    output logic [ADDR_W-1:0]        ramAddr,
    output logic [2*WORD_NIBS-1:0]   ramDin,
    output logic                     ramWriteEn,
    output logic                     cpuHalt,
    output logic                     loadDone,
    output logic [ADDR_W:0]          wordCount,
    output logic                     overflow
);
    localparam int DATA_W = 2 * WORD_NIBS;
    localparam int CNT_W  = $clog2(WORD_NIBS + 1);
    localparam logic [CNT_W-1:0]  LAST_NIB = CNT_W'(WORD_NIBS - 1);
    localparam logic [ADDR_W:0]   MAX_WC   = (ADDR_W + 1)'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_READY} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                cpu_halt_q, cpu_halt_d;
    logic                load_done_q, load_done_d;

    logic [DATA_W-1:0]   next_word;
    logic [DATA_W-1:0]   pad_word;
    logic                full;

    // First color of a word ends up in the MSBs; a partial word is left-justified.
    assign next_word = {shift_q[DATA_W-3:0], color};
    assign pad_word  = shift_q << (2 * (WORD_NIBS - int'(cnt_q)));
    assign full      = (word_count_q == MAX_WC);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        ram_din_d    = ram_din_q;
        ram_we_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        cpu_halt_d   = cpu_halt_q;
        load_done_d  = load_done_q;

        if (loadStart) begin
            state_d      = S_LOAD;
            shift_d      = '0;
            cnt_d        = '0;
            word_count_d = '0;
            overflow_d   = 1'b0;
            load_done_d  = 1'b0;
            cpu_halt_d   = 1'b1;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (colorValid) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else if (cnt_q == LAST_NIB) begin
                            ram_din_d    = next_word;
                            ram_we_d     = 1'b1;
                            wr_addr_d    = word_count_q[ADDR_W-1:0];
                            word_count_d = word_count_q + (ADDR_W + 1)'(1);
                            shift_d      = '0;
                            cnt_d        = '0;
                        end else begin
                            shift_d = next_word;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    // loadEnd looks at the counter after this cycle's color.
                    if (loadEnd) begin
                        if (cnt_d == '0) begin
                            state_d     = S_READY;
                            load_done_d = 1'b1;
                            cpu_halt_d  = 1'b0;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    ram_din_d = pad_word;
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        ram_we_d     = 1'b1;
                        wr_addr_d    = word_count_q[ADDR_W-1:0];
                        word_count_d = word_count_q + (ADDR_W + 1)'(1);
                    end
                    shift_d     = '0;
                    cnt_d       = '0;
                    state_d     = S_READY;
                    load_done_d = 1'b1;
                    cpu_halt_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            ram_din_q    <= '0;
            ram_we_q     <= 1'b0;
            wr_addr_q    <= '0;
            cpu_halt_q   <= 1'b1;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            ram_din_q    <= ram_din_d;
            ram_we_q     <= ram_we_d;
            wr_addr_q    <= wr_addr_d;
            cpu_halt_q   <= cpu_halt_d;
            load_done_q  <= load_done_d;
        end
    end

    // The CPU is halted whenever the loader can write, so the port never contends.
    assign ramAddr    = ram_we_q ? wr_addr_q : cpuAddress;
    assign ramDin     = ram_din_q;
    assign ramWriteEn = ram_we_q;
    assign cpuHalt    = cpu_halt_q;
    assign loadDone   = load_done_q;
    assign wordCount  = word_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cartridge_load_controller.sv
// Directed bench for cartridge_load_controller: a default instance plus a
// MAX_WORDS=2 instance for the overflow boundary, each with a write scoreboard.
module tb_cartridge_load_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reset2 = 1'b0;
    logic        loadStart = 1'b0;
    logic        loadEnd = 1'b0;
    logic        colorValid = 1'b0;
    logic [1:0]  color = 2'd0;
    logic [7:0]  cpuAddress = 8'h5A;

    logic [7:0]  ram_addr, ram_addr2;
    logic [11:0] ram_din, ram_din2;
    logic        ram_we, ram_we2;
    logic        cpu_halt, cpu_halt2;
    logic        load_done, load_done2;
    logic [8:0]  word_count, word_count2;
    logic        ovf, ovf2;

    int err_cnt = 0;
    int chk_cnt = 0;

    // {address, data} of each write expected from each instance, in order.
    logic [19:0] exp_q[$];
    logic [19:0] exp2_q[$];

    cartridge_load_controller dut (
        .clk(clk), .reset(reset), .loadStart(loadStart), .loadEnd(loadEnd),
        .colorValid(colorValid), .color(color), .cpuAddress(cpuAddress),
        .ramAddr(ram_addr), .ramDin(ram_din), .ramWriteEn(ram_we),
        .cpuHalt(cpu_halt), .loadDone(load_done), .wordCount(word_count),
        .overflow(ovf)
    );

    cartridge_load_controller #(.MAX_WORDS(2)) dut2 (
        .clk(clk), .reset(reset2), .loadStart(loadStart), .loadEnd(loadEnd),
        .colorValid(colorValid), .color(color), .cpuAddress(cpuAddress),
        .ramAddr(ram_addr2), .ramDin(ram_din2), .ramWriteEn(ram_we2),
        .cpuHalt(cpu_halt2), .loadDone(load_done2), .wordCount(word_count2),
        .overflow(ovf2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_q.size() == 0) check_eq("unexpected_write", {ram_addr, ram_din}, 20'h0);
            else check_eq("write", {ram_addr, ram_din}, exp_q.pop_front());
        end
        if (ram_we2) begin
            if (exp2_q.size() == 0) check_eq("unexpected_write2", {ram_addr2, ram_din2}, 20'h0);
            else check_eq("write2", {ram_addr2, ram_din2}, exp2_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic with_end);
        colorValid = 1'b1;
        color      = c;
        loadEnd    = with_end;
        tick();
        colorValid = 1'b0;
        loadEnd    = 1'b0;
    endtask

    task automatic start_load();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
    endtask

    task automatic end_load();
        loadEnd = 1'b1;
        tick();
        loadEnd = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("rst_we", ram_we, 0);
        check_eq("rst_din", ram_din, 0);
        check_eq("rst_wc", word_count, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_done", load_done, 0);
        check_eq("rst_halt", cpu_halt, 1);
        check_eq("rst_addr", ram_addr, 8'h5A);

        // IDLE ignores colors and loadEnd
        send(2'd3, 1'b1);
        tick();
        check_eq("idle_wc", word_count, 0);
        check_eq("idle_done", load_done, 0);

        // One word, consecutive colors 0,1,2,3,0,1 -> 0x1B1 @0
        start_load();
        exp_q.push_back({8'd0, 12'h1B1});
        send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0);
        send(2'd3, 1'b0); send(2'd0, 1'b0);
        check_eq("t1_no_early_we", ram_we, 0);
        send(2'd1, 1'b0);
        check_eq("t1_we", ram_we, 1);
        check_eq("t1_addr", ram_addr, 0);
        check_eq("t1_din", ram_din, 12'h1B1);
        check_eq("t1_wc", word_count, 1);
        tick();
        check_eq("t1_we_drop", ram_we, 0);
        check_eq("t1_halt", cpu_halt, 1);

        // Two words with idle gaps, then loadEnd with an empty counter
        start_load();
        exp_q.push_back({8'd0, 12'hFFF});
        exp_q.push_back({8'd1, 12'hAAA});
        for (int i = 0; i < 6; i++) begin send(2'd3, 1'b0); tick(); end
        for (int i = 0; i < 6; i++) begin send(2'd2, 1'b0); tick(); end
        end_load();
        check_eq("t2_done", load_done, 1);
        check_eq("t2_halt", cpu_halt, 0);
        check_eq("t2_wc", word_count, 2);
        cpuAddress = 8'h33;
        #1;
        check_eq("t2_cpu_addr", ram_addr, 8'h33);
        send(2'd1, 1'b0);
        send(2'd1, 1'b1);
        check_eq("t2_ready_ignores", word_count, 2);
        check_eq("t2_q_empty", exp_q.size(), 0);

        // Partial word flushed: 3,3 -> 0xF00 @0
        start_load();
        check_eq("t3_done_clr", load_done, 0);
        check_eq("t3_halt_set", cpu_halt, 1);
        exp_q.push_back({8'd0, 12'hF00});
        send(2'd3, 1'b0);
        send(2'd3, 1'b0);
        end_load();
        check_eq("t3_flush_state", load_done, 0);
        tick();
        check_eq("t3_we", ram_we, 1);
        check_eq("t3_din", ram_din, 12'hF00);
        check_eq("t3_wc", word_count, 1);
        check_eq("t3_done", load_done, 1);

        // 6th color together with loadEnd -> direct to READY, no flush write
        start_load();
        exp_q.push_back({8'd0, 12'h555});
        for (int i = 0; i < 5; i++) send(2'd1, 1'b0);
        send(2'd1, 1'b1);
        check_eq("t4_we", ram_we, 1);
        check_eq("t4_done", load_done, 1);
        tick();
        tick();
        check_eq("t4_no_flush", ram_we, 0);
        check_eq("t4_wc", word_count, 1);
        check_eq("t4_q_empty", exp_q.size(), 0);

        // Reset on the edge of a 6th color suppresses the write
        start_load();
        for (int i = 0; i < 5; i++) send(2'd2, 1'b0);
        reset = 1'b0;
        send(2'd2, 1'b0);
        reset = 1'b1;
        check_eq("t5_we", ram_we, 0);
        check_eq("t5_din", ram_din, 0);
        check_eq("t5_wc", word_count, 0);
        check_eq("t5_halt", cpu_halt, 1);
        check_eq("t5_done", load_done, 0);
        tick();
        check_eq("t5_we_after", ram_we, 0);

        // loadStart mid-word discards the partial word
        start_load();
        send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0);
        start_load();
        exp_q.push_back({8'd0, 12'h003});
        for (int i = 0; i < 5; i++) send(2'd0, 1'b0);
        send(2'd3, 1'b0);
        check_eq("t6_din", ram_din, 12'h003);
        check_eq("t6_wc", word_count, 1);

        // Overflow: MAX_WORDS=2 instance drops the 13th color
        reset2 = 1'b1;
        tick();
        start_load();
        exp_q.push_back({8'd0, 12'h555});
        exp_q.push_back({8'd1, 12'hAAA});
        exp2_q.push_back({8'd0, 12'h555});
        exp2_q.push_back({8'd1, 12'hAAA});
        for (int i = 0; i < 6; i++) send(2'd1, 1'b0);
        for (int i = 0; i < 6; i++) send(2'd2, 1'b0);
        check_eq("t7_full_no_ovf", ovf2, 0);
        check_eq("t7_wc2_full", word_count2, 2);
        send(2'd3, 1'b0);
        check_eq("t7_ovf2", ovf2, 1);
        check_eq("t7_wc2", word_count2, 2);
        check_eq("t7_ovf1", ovf, 0);
        exp_q.push_back({8'd2, 12'hC00});
        end_load();
        check_eq("t7_done2", load_done2, 1);
        check_eq("t7_ovf2_sticky", ovf2, 1);
        tick();
        check_eq("t7_wc1_flush", word_count, 3);
        start_load();
        check_eq("t7_ovf2_clr", ovf2, 0);
        check_eq("t7_wc2_clr", word_count2, 0);

        tick();
        tick();
        check_eq("final_q_empty", exp_q.size(), 0);
        check_eq("final_q2_empty", exp2_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cartridge_load_controller.md
Name: cartridge_load_controller

Overview:
- Sequences the cartridge-read phase into program RAM.
- Each `detectionComplete` pulse from the color detector delivers one 2-bit color. The block packs six consecutive colors into one 12-bit instruction word and writes it to the next RAM address.
- Arbitrates the single RAM address port between loader writes and CPU instruction fetches.
- Holds the CPU halted until the load is finished.

Parameters:
- WORD_NIBS, 6, colors packed per RAM word (DATA_W = 2*WORD_NIBS).
- ADDR_W, 8, RAM address width.
- MAX_WORDS, 256, words accepted before overflow; must satisfy 1 <= MAX_WORDS <= 2^ADDR_W.

Ports:
- clk  in  1  system clock (1 MHz divided clock).
- reset  in  1  synchronous, active-low reset; one clock; sampled on posedge clk only.
- loadStart  in  1  single-cycle pulse, begins a new load (from motion controller).
- loadEnd  in  1  single-cycle pulse, cartridge scan finished.
- colorValid  in  1  single-cycle pulse, color input valid this cycle.
- color  in  2  detected color (00 R, 01 G, 10 B, 11 Y).
- cpuAddress  in  ADDR_W  CPU program counter.
- ramAddr  out  ADDR_W  RAM address (arbitrated).
- ramDin  out  2*WORD_NIBS  RAM write data.
- ramWriteEn  out  1  RAM write strobe, one cycle per word.
- cpuHalt  out  1  1 = CPU must not execute.
- loadDone  out  1  level, high in READY.
- wordCount  out  ADDR_W+1  words written this load.
- overflow  out  1  sticky, a color was dropped because MAX_WORDS was reached.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; ramWriteEn=0, ramDin=0, wordCount=0, overflow=0, loadDone=0, cpuHalt=1; shift register and color counter cleared.
  - Reset mid-load discards the partial word.
  - A write strobe pending at that edge is suppressed.
- States: IDLE, LOAD, FLUSH, READY.
- IDLE:
  - cpuHalt=1.
  - loadStart -> LOAD.
- LOAD entry (from any state, on loadStart):
  - Clear wordCount, overflow, shift register, color counter.
  - loadDone<=0, cpuHalt<=1.
  - loadStart during LOAD or FLUSH restarts the load in the same way; the partial word is discarded.
- LOAD, colorValid:
  - next = {shift[2*WORD_NIBS-3:0], color}, so the first color lands in the MSBs.
  - If counter < WORD_NIBS-1: shift<=next, counter++.
  - If counter == WORD_NIBS-1: ramDin<=next, ramWriteEn<=1 next cycle with write address = wordCount (pre-increment); wordCount++, shift<=0, counter<=0.
- Write latency: colorValid at edge n produces ramWriteEn high for exactly the cycle after edge n.
  - ramWriteEn is registered and deasserts after one cycle.
  - Back-to-back colorValid is legal; no color is lost.
- Overflow:
  - If wordCount == MAX_WORDS when a color arrives, the color is dropped and overflow<=1.
  - overflow stays set until the next loadStart or reset.
- loadEnd in LOAD:
  - If colorValid is simultaneous, the color is accepted first, then loadEnd is applied using the updated counter.
  - counter==0 -> READY.
  - counter>0 -> FLUSH.
- FLUSH (1 cycle):
  - ramDin <= shift << 2*(WORD_NIBS-counter), i.e. zero-padded into the LSBs.
  - ramWriteEn pulses, unless wordCount==MAX_WORDS, in which case overflow<=1 and no write.
  - wordCount++ when written; -> READY.
- READY:
  - loadDone=1, cpuHalt=0.
  - colorValid and loadEnd are ignored.
  - Stays until loadStart or reset.
- Inputs ignored per state:
  - IDLE: colorValid and loadEnd are ignored.
  - FLUSH: colorValid is ignored.
- Arbitration (combinational): ramAddr = ramWriteEn ? writeAddr_reg : cpuAddress.
  - The CPU is halted whenever writes can occur, so no contention.
  - The CPU sees its own address in IDLE and READY.
- cpuHalt and loadDone are registered and change on the edge that enters or leaves READY.

Test Plan:
- Reset, loadStart, colors 0,1,2,3,0,1 on consecutive cycles -> one ramWriteEn pulse the cycle after the 6th color, ramAddr=0, ramDin=0x1B1, wordCount=1.
- 12 colors (all 3, then all 2) with idle gaps, then loadEnd -> writes 0xFFF @0 and 0xAAA @1; READY with loadDone=1, cpuHalt=0, wordCount=2; ramAddr follows cpuAddress afterwards.
- Colors 3,3 then loadEnd -> FLUSH writes 0xF00 @0; wordCount=1; READY.
- 6th color and loadEnd in the same cycle -> full word written, then READY directly with no FLUSH write; wordCount=1.
- MAX_WORDS=2, 13 colors -> two writes; 13th color dropped; overflow=1.
- Mid-load cases:
  - reset low mid-word -> all outputs at reset values, no write pulse.
  - loadStart mid-word -> partial discarded, next 6 colors are written to address 0.
